// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command packet layer.
//   rx_state_t / tx_state_t : receive-framing and transmit FSM states
//   PKT_BYTES               : bytes per packet (4 when UART_CMD_CHKSUM_EN is defined)
//   FAST_SIM_TIMEOUT        : inter-byte timeout used in fast simulation builds
//   pkt_cksum()             : inverted modulo-256 sum of the three packet bytes
// Optional feature macro: UART_CMD_CHKSUM_EN (adds a trailing checksum byte).
package uart_cmd_pkg;

`ifdef UART_CMD_CHKSUM_EN
  localparam int unsigned PKT_BYTES = 4;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO, WAIT_CK} rx_state_t;
`else
  localparam int unsigned PKT_BYTES = 3;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} rx_state_t;
`endif

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  localparam int unsigned FAST_SIM_TIMEOUT = 64;

  function automatic logic [7:0] pkt_cksum(input logic [7:0] c,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo);
    logic [7:0] sum;
    sum = c + hi + lo;
    return ~sum;
  endfunction

endpackage

// File: rtl/uart_cmd_assembler_byte_timeout_ctr.sv
// byte_timeout_ctr: 16-bit saturating idle counter.
//   clk, rst (async, active-high)
//   clr     : zero the count (has priority over en)
//   en      : advance the count by one
//   expired : count has reached LIMIT (limit clipped to the 16-bit range)
module byte_timeout_ctr #(
  parameter int unsigned LIMIT = 49999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned LIM_SAT = (LIMIT > 65535) ? 65535 : LIMIT;
  localparam logic [15:0] LIM = 16'(LIM_SAT);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    count <= '0;
    else if (clr)               count <= '0;
    else if (en && count != '1) count <= count + 16'd1;
  end

  assign expired = (count >= LIM);

endmodule

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: frames UART bytes into cmd/data packets for cmd_cfg and
// forwards cmd_cfg's one-byte response to the UART transmitter.
//   clk, DUT_clr_cmd_rdy (async active-high reset)
//   rx_rdy/rx_data/clr_rx_rdy      : UART receiver byte handshake
//   cmd_rdy/cmd/data/clr_cmd_rdy   : packet handshake towards cmd_cfg
//   resp/send_resp                 : response request from cmd_cfg
//   trmt/tx_data/tx_done/resp_sent : UART transmitter handshake
//   frame_err                      : one-cycle pulse when a partial/bad packet is dropped
// Optional feature macro: UART_CMD_CHKSUM_EN (4th checksum byte gates cmd_rdy).
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 50000,
  parameter logic        FAST_SIM     = 1'b0
) (
  input  logic        clk,
  input  logic        DUT_clr_cmd_rdy,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic        frame_err
);

  localparam int unsigned TO_LIMIT = FAST_SIM ? FAST_SIM_TIMEOUT - 1 : BYTE_TIMEOUT - 1;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic cap_cmd, cap_hi, cap_lo, set_rdy, drop_rdy, fire_err;
  logic ctr_clr, ctr_en, expired;
  logic latch_resp, done_pulse;

  byte_timeout_ctr #(.LIMIT(TO_LIMIT)) u_timeout (
    .clk     (clk),
    .rst     (DUT_clr_cmd_rdy),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  // Byte is consumed in the same cycle it is offered; masked during reset so
  // every output reads 0 while reset is held.
  assign clr_rx_rdy = rx_rdy & ~DUT_clr_cmd_rdy;

  always_ff @(posedge clk or posedge DUT_clr_cmd_rdy) begin
    if (DUT_clr_cmd_rdy) begin
      rx_state <= WAIT_CMD;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  // A byte arriving in the cycle the timeout expires takes precedence.
  always_comb begin
    rx_next  = rx_state;
    cap_cmd  = 1'b0;
    cap_hi   = 1'b0;
    cap_lo   = 1'b0;
    set_rdy  = 1'b0;
    drop_rdy = 1'b0;
    fire_err = 1'b0;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    case (rx_state)
      WAIT_CMD: begin
        ctr_clr = 1'b1;
        if (rx_rdy) begin
          cap_cmd  = 1'b1;
          drop_rdy = 1'b1;
          rx_next  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rx_rdy) begin
          cap_hi  = 1'b1;
          ctr_clr = 1'b1;
          rx_next = WAIT_LO;
        end else if (expired) begin
          fire_err = 1'b1;
          ctr_clr  = 1'b1;
          rx_next  = WAIT_CMD;
        end else begin
          ctr_en = 1'b1;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          cap_lo  = 1'b1;
          ctr_clr = 1'b1;
`ifdef UART_CMD_CHKSUM_EN
          rx_next = WAIT_CK;
`else
          set_rdy = 1'b1;
          rx_next = WAIT_CMD;
`endif
        end else if (expired) begin
          fire_err = 1'b1;
          ctr_clr  = 1'b1;
          rx_next  = WAIT_CMD;
        end else begin
          ctr_en = 1'b1;
        end
      end
`ifdef UART_CMD_CHKSUM_EN
      WAIT_CK: begin
        if (rx_rdy) begin
          ctr_clr = 1'b1;
          rx_next = WAIT_CMD;
          if (rx_data == pkt_cksum(cmd, data[15:8], data[7:0])) set_rdy  = 1'b1;
          else                                                  fire_err = 1'b1;
        end else if (expired) begin
          fire_err = 1'b1;
          ctr_clr  = 1'b1;
          rx_next  = WAIT_CMD;
        end else begin
          ctr_en = 1'b1;
        end
      end
`endif
      default: rx_next = WAIT_CMD;
    endcase
  end

  always_comb begin
    tx_next    = tx_state;
    latch_resp = 1'b0;
    done_pulse = 1'b0;
    case (tx_state)
      TX_IDLE: if (send_resp) begin
        latch_resp = 1'b1;
        tx_next    = TX_BUSY;
      end
      TX_BUSY: if (tx_done) begin
        done_pulse = 1'b1;
        tx_next    = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge DUT_clr_cmd_rdy) begin
    if (DUT_clr_cmd_rdy) begin
      cmd       <= '0;
      data      <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
      trmt      <= 1'b0;
      tx_data   <= '0;
      resp_sent <= 1'b0;
    end else begin
      if (cap_cmd) cmd        <= rx_data;
      if (cap_hi)  data[15:8] <= rx_data;
      if (cap_lo)  data[7:0]  <= rx_data;
      // Completion beats a coincident acknowledge.
      if (set_rdy)                      cmd_rdy <= 1'b1;
      else if (drop_rdy || clr_cmd_rdy) cmd_rdy <= 1'b0;
      frame_err <= fire_err;
      trmt      <= latch_resp;
      resp_sent <= done_pulse;
      if (latch_resp) tx_data <= resp;
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
module tb_uart_cmd_assembler;

  logic        clk = 1'b0;
  logic        DUT_clr_cmd_rdy;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;
  logic        frame_err;

  uart_cmd_assembler #(.BYTE_TIMEOUT(50000), .FAST_SIM(1'b1)) dut (
    .clk             (clk),
    .DUT_clr_cmd_rdy (DUT_clr_cmd_rdy),
    .rx_rdy          (rx_rdy),
    .rx_data         (rx_data),
    .clr_rx_rdy      (clr_rx_rdy),
    .cmd_rdy         (cmd_rdy),
    .cmd             (cmd),
    .data            (data),
    .clr_cmd_rdy     (clr_cmd_rdy),
    .resp            (resp),
    .send_resp       (send_resp),
    .trmt            (trmt),
    .tx_data         (tx_data),
    .tx_done         (tx_done),
    .resp_sent       (resp_sent),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int slot; logic [7:0] c; logic [15:0] d; } pkt_t;
  typedef struct { int slot; logic [7:0] b; } tx_t;

  pkt_t q_pkt[$];
  int   q_err[$];
  tx_t  q_trmt[$];
  int   q_sent[$];
  logic exp_rdy[int];

  int checks = 0;
  int passed = 0;

  // Reference model state: bytes of the packet in progress, slot of the last
  // accepted byte, expected cmd_rdy level, and whether a response is in flight.
  logic [7:0] pkt[3];
  int   npend = 0;
  int   last_slot = 0;
  logic rdy_cur = 1'b0;
  logic tx_busy = 1'b0;

  // Inter-byte budget in slots: a byte 64 slots after the previous one is still
  // accepted, a gap of 65 means the timeout already fired.
  localparam int GAP_LIMIT = 65;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at slot %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  task automatic slot(input logic bv, input logic [7:0] b, input logic clr,
                      input logic snd, input logic [7:0] r, input logic dn);
    int   s;
    logic nxt;
    logic done_pkt;
    @(posedge clk); #2;
    s = cyc;
    DUT_clr_cmd_rdy = 1'b0;
    rx_rdy = bv; rx_data = b; clr_cmd_rdy = clr;
    send_resp = snd; resp = r; tx_done = dn;

    if (npend > 0 && s - last_slot >= GAP_LIMIT) begin
      q_err.push_back(s);
      npend = 0;
    end

    nxt = rdy_cur;
    done_pkt = 1'b0;
    if (bv) begin
      pkt[npend] = b;
      npend++;
      last_slot = s;
      if (npend == 1) nxt = 1'b0;
      if (npend == 3) begin
        q_pkt.push_back('{s + 1, pkt[0], {pkt[1], pkt[2]}});
        npend = 0;
        done_pkt = 1'b1;
      end
    end
    if (done_pkt) nxt = 1'b1;
    else if (clr) nxt = 1'b0;
    exp_rdy[s + 1] = nxt;
    rdy_cur = nxt;

    if (tx_busy) begin
      if (dn) begin
        q_sent.push_back(s + 1);
        tx_busy = 1'b0;
      end
    end else if (snd) begin
      q_trmt.push_back('{s + 1, r});
      tx_busy = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    slot(1'b1, b, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic reset_slots(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      DUT_clr_cmd_rdy = 1'b1;
      rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
      send_resp = 1'b0; resp = '0; tx_done = 1'b0;
      npend = 0; tx_busy = 1'b0; rdy_cur = 1'b0;
      exp_rdy[cyc] = 1'b0;
      exp_rdy[cyc + 1] = 1'b0;
      q_pkt.delete(); q_err.delete(); q_trmt.delete(); q_sent.delete();
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations, mid-cycle.
  logic        prev_rdy = 1'b0;
  logic [23:0] cur_pkt = '0;
  logic [7:0]  hold_tx = '0;

  always @(negedge clk) begin
    if (DUT_clr_cmd_rdy) begin
      chk("reset_outputs_zero",
          {27'd0, clr_rx_rdy, cmd_rdy, cmd, data, trmt, tx_data, resp_sent, frame_err}, 64'd0);
      hold_tx  = '0;
      prev_rdy = 1'b0;
      exp_rdy.delete(cyc);
    end else begin
      chk("clr_rx_rdy_follows_rx_rdy", clr_rx_rdy, rx_rdy);

      if (exp_rdy.exists(cyc)) begin
        chk("cmd_rdy_level", cmd_rdy, exp_rdy[cyc]);
        exp_rdy.delete(cyc);
      end

      if (q_pkt.size() > 0 && q_pkt[0].slot < cyc) begin
        chk("pkt_missing_slot", cyc, q_pkt[0].slot);
        void'(q_pkt.pop_front());
      end
      if (q_err.size() > 0 && q_err[0] < cyc) begin
        chk("frame_err_missing_slot", cyc, q_err[0]);
        void'(q_err.pop_front());
      end
      if (q_trmt.size() > 0 && q_trmt[0].slot < cyc) begin
        chk("trmt_missing_slot", cyc, q_trmt[0].slot);
        void'(q_trmt.pop_front());
      end
      if (q_sent.size() > 0 && q_sent[0] < cyc) begin
        chk("resp_sent_missing_slot", cyc, q_sent[0]);
        void'(q_sent.pop_front());
      end

      if (cmd_rdy && !prev_rdy) begin
        if (q_pkt.size() == 0) chk("cmd_rdy_unexpected", 1, 0);
        else begin
          pkt_t p;
          p = q_pkt.pop_front();
          chk("cmd_rdy_rise_slot", cyc, p.slot);
          chk("pkt_cmd_data", {cmd, data}, {p.c, p.d});
          cur_pkt = {p.c, p.d};
        end
      end
      if (cmd_rdy) chk("pkt_stable_while_rdy", {cmd, data}, cur_pkt);

      if (frame_err) begin
        if (q_err.size() == 0) chk("frame_err_unexpected", 1, 0);
        else chk("frame_err_slot", cyc, q_err.pop_front());
      end

      if (trmt) begin
        if (q_trmt.size() == 0) chk("trmt_unexpected", 1, 0);
        else begin
          tx_t t;
          t = q_trmt.pop_front();
          chk("trmt_slot", cyc, t.slot);
          chk("trmt_tx_data", tx_data, t.b);
          hold_tx = t.b;
        end
      end
      chk("tx_data_hold", tx_data, hold_tx);

      if (resp_sent) begin
        if (q_sent.size() == 0) chk("resp_sent_unexpected", 1, 0);
        else chk("resp_sent_slot", cyc, q_sent.pop_front());
      end

      prev_rdy = cmd_rdy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at slot %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    DUT_clr_cmd_rdy = 1'b1;
    rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp = '0; tx_done = 1'b0;
    reset_slots(3);
    idle(5);

    // Spaced packet, then acknowledge.
    send_byte(8'h02); idle(19);
    send_byte(8'h13); idle(19);
    send_byte(8'h37); idle(4);
    slot(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(3);

    // Partial packet times out, then a clean packet.
    send_byte(8'h05); idle(3);
    send_byte(8'h0A); idle(70);
    send_byte(8'h03); send_byte(8'hAA); send_byte(8'hAA);
    idle(3);

    // cmd_rdy left high; new packet drops it; ack coincides with completion.
    send_byte(8'h04); idle(2);
    send_byte(8'h12); idle(2);
    slot(1'b1, 8'h34, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(3);

    // Response path: second request while busy and request on tx_done dropped.
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0); idle(2);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0); idle(3);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1); idle(3);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0); idle(2);
    slot(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1); idle(3);

    // Timeout boundary: gap of 64 accepted, gap of 65 restarts framing.
    send_byte(8'h07); idle(63);
    send_byte(8'hAB); idle(63);
    send_byte(8'hCD); idle(3);
    send_byte(8'h08); idle(64);
    send_byte(8'h09); send_byte(8'h0B); send_byte(8'h0C);
    idle(3);

    // Reset mid-packet and mid-transmit, then recovery.
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0);
    send_byte(8'h21); send_byte(8'h22); idle(2);
    reset_slots(2);
    idle(3);
    send_byte(8'h06); send_byte(8'h00); send_byte(8'h00);
    idle(3);

    // Randomized traffic on both paths with occasional long silences.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) idle(int'($urandom_range(60, 70)));
      slot($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) < 8, 8'($urandom), $urandom_range(0, 99) < 10);
    end

    idle(80);
    chk("pkt_queue_drained", q_pkt.size(), 0);
    chk("frame_err_queue_drained", q_err.size(), 0);
    chk("trmt_queue_drained", q_trmt.size(), 0);
    chk("resp_sent_queue_drained", q_sent.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
